// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: sequencer states,
// opcode/funct codes and the datapath mux/ALU select values.
package mips_pkg;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC1  = 3'd3,
        ST_EXEC2  = 3'd4,
        ST_MDWAIT = 3'd5,
        ST_HALT   = 3'd6,
        ST_FAULT  = 3'd7
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03,
                           OP_BEQ   = 6'h04, OP_BNE   = 6'h05, OP_ADDIU = 6'h09,
                           OP_SLTI  = 6'h0a, OP_SLTIU = 6'h0b, OP_ANDI  = 6'h0c,
                           OP_ORI   = 6'h0d, OP_XORI  = 6'h0e, OP_LUI   = 6'h0f,
                           OP_LW    = 6'h23, OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL   = 6'h02, FN_SRA  = 6'h03,
                           FN_SLLV = 6'h04, FN_SRLV  = 6'h06, FN_SRAV = 6'h07,
                           FN_JR   = 6'h08, FN_JALR  = 6'h09, FN_MFHI = 6'h10,
                           FN_MFLO = 6'h12, FN_MULT  = 6'h18, FN_MULTU = 6'h19,
                           FN_DIV  = 6'h1a, FN_DIVU  = 6'h1b, FN_ADD  = 6'h20,
                           FN_ADDU = 6'h21, FN_SUB   = 6'h22, FN_SUBU = 6'h23,
                           FN_AND  = 6'h24, FN_OR    = 6'h25, FN_XOR  = 6'h26,
                           FN_NOR  = 6'h27, FN_SLT   = 6'h2a, FN_SLTU = 6'h2b;

    localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_FUNCT = 3'b010,
                           ALU_AND = 3'b011, ALU_OR  = 3'b100, ALU_XOR   = 3'b101,
                           ALU_SLT = 3'b110, ALU_SLTU = 3'b111;

    localparam logic [1:0] RD_RT = 2'd0, RD_RD = 2'd1, RD_R31 = 2'd2;
    localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC8 = 2'd2, WB_LUI = 2'd3;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_src;
        logic       zero_ext;
        logic       jump;
        logic       jump_reg;
        logic       branch;
        logic       branch_ne;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
    } ctrl_t;

    // R-type functs that simply write the ALU result to rd
    function automatic logic is_alu_funct(input logic [5:0] f);
        return f inside {FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
                         FN_MFHI, FN_MFLO, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                         FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU};
    endfunction

endpackage

// File: rtl/mips_decode.sv
// Combinational instruction decode: opcode/funct to datapath control fields,
// instruction class flags and an illegal-instruction flag.
module mips_decode
    import mips_pkg::*;
#(
    parameter int MULDIV_EN = 1
) (
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output ctrl_t      ctrl,
    output logic       writes_reg,
    output logic       is_lw,
    output logic       is_sw,
    output logic       is_muldiv,
    output logic       is_jr,
    output logic       illegal
);

    always_comb begin
        ctrl       = '0;
        writes_reg = 1'b0;
        is_lw      = 1'b0;
        is_sw      = 1'b0;
        is_muldiv  = 1'b0;
        is_jr      = 1'b0;
        illegal    = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                if (is_alu_funct(funct)) begin
                    ctrl.alu_op = ALU_FUNCT;
                    ctrl.regdst = RD_RD;
                    writes_reg  = 1'b1;
                end else if (funct == FN_JR) begin
                    ctrl.jump_reg = 1'b1;
                    is_jr         = 1'b1;
                end else if (funct == FN_JALR) begin
                    ctrl.jump_reg = 1'b1;
                    ctrl.regdst   = RD_RD;
                    ctrl.memtoreg = WB_PC8;
                    writes_reg    = 1'b1;
                    is_jr         = 1'b1;
                end else if ((MULDIV_EN != 0) &&
                             (funct inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU})) begin
                    ctrl.alu_op = ALU_FUNCT;
                    is_muldiv   = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_ADDIU: begin ctrl.alu_op = ALU_ADD;  ctrl.alu_src = 1'b1; writes_reg = 1'b1; end
            OP_ANDI:  begin ctrl.alu_op = ALU_AND;  ctrl.alu_src = 1'b1; ctrl.zero_ext = 1'b1; writes_reg = 1'b1; end
            OP_ORI:   begin ctrl.alu_op = ALU_OR;   ctrl.alu_src = 1'b1; ctrl.zero_ext = 1'b1; writes_reg = 1'b1; end
            OP_XORI:  begin ctrl.alu_op = ALU_XOR;  ctrl.alu_src = 1'b1; ctrl.zero_ext = 1'b1; writes_reg = 1'b1; end
            OP_SLTI:  begin ctrl.alu_op = ALU_SLT;  ctrl.alu_src = 1'b1; writes_reg = 1'b1; end
            OP_SLTIU: begin ctrl.alu_op = ALU_SLTU; ctrl.alu_src = 1'b1; writes_reg = 1'b1; end
            OP_LUI:   begin ctrl.memtoreg = WB_LUI; writes_reg = 1'b1; end
            OP_LW:    begin ctrl.alu_src = 1'b1; ctrl.memtoreg = WB_MEM; writes_reg = 1'b1; is_lw = 1'b1; end
            OP_SW:    begin ctrl.alu_src = 1'b1; is_sw = 1'b1; end
            OP_BEQ:   begin ctrl.alu_op = ALU_SUB; ctrl.branch = 1'b1; end
            OP_BNE:   begin ctrl.alu_op = ALU_SUB; ctrl.branch_ne = 1'b1; end
            OP_J:     ctrl.jump = 1'b1;
            OP_JAL:   begin
                ctrl.jump     = 1'b1;
                ctrl.regdst   = RD_R31;
                ctrl.memtoreg = WB_PC8;
                writes_reg    = 1'b1;
            end
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_sequencer.sv
// Multicycle MIPS control sequencer: owns the state register and turns the
// decoded instruction into per-state datapath and Avalon strobes.
module mips_sequencer
    import mips_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 0,
    parameter int TMO_W        = 16,
    parameter int MULDIV_EN    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       waitrequest,
    input  logic       alu_busy,
    input  logic       jr_target_zero,
    output logic [2:0] state,
    output logic       active,
    output logic       fault,
    output logic [2:0] alu_op,
    output logic       alu_src,
    output logic       zero_ext,
    output logic       jump,
    output logic       jump_reg,
    output logic       branch,
    output logic       branch_ne,
    output logic [1:0] regdst,
    output logic [1:0] memtoreg,
    output logic       memread,
    output logic       memwrite,
    output logic       regwrite,
    output logic       inwrite,
    output logic       pctoadd,
    output logic       pcwrite,
    output logic       muldiv_start
);

    state_t           st, nxt;
    logic [TMO_W-1:0] tmo_cnt;
    ctrl_t            ctrl, ctrl_out;
    logic             writes_reg, is_lw, is_sw, is_muldiv, is_jr, illegal;
    logic             fields_en, tmo_hit;

    mips_decode #(.MULDIV_EN(MULDIV_EN)) u_decode (
        .opcode     (opcode),
        .funct      (funct),
        .ctrl       (ctrl),
        .writes_reg (writes_reg),
        .is_lw      (is_lw),
        .is_sw      (is_sw),
        .is_muldiv  (is_muldiv),
        .is_jr      (is_jr),
        .illegal    (illegal)
    );

    assign tmo_hit = (WAIT_TIMEOUT > 0) && (tmo_cnt == TMO_W'(WAIT_TIMEOUT));

    // The counter only tracks stalls of an actually issued bus request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st      <= ST_RESET;
            tmo_cnt <= '0;
        end else begin
            st      <= nxt;
            tmo_cnt <= (waitrequest && (memread || memwrite)) ? tmo_cnt + TMO_W'(1) : '0;
        end
    end

    always_comb begin
        nxt          = st;
        fields_en    = 1'b0;
        memread      = 1'b0;
        memwrite     = 1'b0;
        regwrite     = 1'b0;
        inwrite      = 1'b0;
        pctoadd      = 1'b0;
        pcwrite      = 1'b0;
        muldiv_start = 1'b0;
        case (st)
            ST_RESET:  nxt = ST_FETCH;
            ST_FETCH: begin
                if (tmo_hit) begin
                    nxt = ST_FAULT;
                end else begin
                    pctoadd = 1'b1;
                    memread = 1'b1;
                    if (!waitrequest) nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                inwrite = 1'b1;
                nxt     = illegal ? ST_FAULT : ST_EXEC1;
            end
            ST_EXEC1: begin
                fields_en = 1'b1;
                if (is_lw) begin
                    if (tmo_hit) begin
                        nxt = ST_FAULT;
                    end else begin
                        memread = 1'b1;
                        if (!waitrequest) nxt = ST_EXEC2;
                    end
                end else if (is_muldiv) begin
                    muldiv_start = 1'b1;
                    nxt          = ST_MDWAIT;
                end else begin
                    nxt = ST_EXEC2;
                end
            end
            ST_MDWAIT: begin
                fields_en = 1'b1;
                if (!alu_busy) nxt = ST_EXEC2;
            end
            // Writeback commits only once the bus is free, so each
            // instruction retires with exactly one pc/reg write
            ST_EXEC2: begin
                fields_en = 1'b1;
                if (tmo_hit) begin
                    nxt = ST_FAULT;
                end else begin
                    memwrite = is_sw;
                    if (!waitrequest) begin
                        pcwrite  = 1'b1;
                        regwrite = writes_reg;
                        nxt      = (is_jr && jr_target_zero) ? ST_HALT : ST_FETCH;
                    end
                end
            end
            default: nxt = st;
        endcase
    end

    assign ctrl_out  = fields_en ? ctrl : '0;
    assign alu_op    = ctrl_out.alu_op;
    assign alu_src   = ctrl_out.alu_src;
    assign zero_ext  = ctrl_out.zero_ext;
    assign jump      = ctrl_out.jump;
    assign jump_reg  = ctrl_out.jump_reg;
    assign branch    = ctrl_out.branch;
    assign branch_ne = ctrl_out.branch_ne;
    assign regdst    = ctrl_out.regdst;
    assign memtoreg  = ctrl_out.memtoreg;

    assign state  = st;
    assign active = !(st inside {ST_RESET, ST_HALT, ST_FAULT});
    assign fault  = (st == ST_FAULT);

endmodule

// File: tb/tb_mips_sequencer.sv
// Bench for mips_sequencer: builds an expected per-cycle trace for each
// instruction from the instruction table and stall counts, then replays it.
module tb_mips_sequencer;

    logic       clk = 1'b0;
    logic       reset, waitrequest, alu_busy, jr_target_zero;
    logic [5:0] opcode, funct;
    logic [2:0] state, alu_op;
    logic       active, fault, alu_src, zero_ext, jump, jump_reg, branch, branch_ne;
    logic [1:0] regdst, memtoreg;
    logic       memread, memwrite, regwrite, inwrite, pctoadd, pcwrite, muldiv_start;
    logic [21:0] obs;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mips_sequencer #(.WAIT_TIMEOUT(4), .TMO_W(16), .MULDIV_EN(1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .waitrequest(waitrequest), .alu_busy(alu_busy), .jr_target_zero(jr_target_zero),
        .state(state), .active(active), .fault(fault), .alu_op(alu_op),
        .alu_src(alu_src), .zero_ext(zero_ext), .jump(jump), .jump_reg(jump_reg),
        .branch(branch), .branch_ne(branch_ne), .regdst(regdst), .memtoreg(memtoreg),
        .memread(memread), .memwrite(memwrite), .regwrite(regwrite), .inwrite(inwrite),
        .pctoadd(pctoadd), .pcwrite(pcwrite), .muldiv_start(muldiv_start)
    );

    assign obs = {active, fault, alu_op, alu_src, zero_ext, jump, jump_reg, branch,
                  branch_ne, regdst, memtoreg, memread, memwrite, regwrite, inwrite,
                  pctoadd, pcwrite, muldiv_start};

    typedef struct packed {
        logic       legal;
        logic [2:0] alu_op;
        logic       alu_src, zext, jump, jreg, br, bne;
        logic [1:0] regdst, m2r;
        logic       wr, lw, sw, md, jrx;
    } info_t;

    typedef struct packed {
        logic        wr;
        logic        busy;
        logic [2:0]  st;
        logic [21:0] out;
    } cyc_t;

    cyc_t tr[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic info_t decode_ref(input logic [5:0] op, input logic [5:0] fn);
        info_t d = '0;
        d.legal = 1'b1;
        case (op)
            6'h00: case (fn)
                6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12,
                6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                6'h2a, 6'h2b: begin d.alu_op = 3'b010; d.regdst = 2'd1; d.wr = 1'b1; end
                6'h08: begin d.jreg = 1'b1; d.jrx = 1'b1; end
                6'h09: begin d.jreg = 1'b1; d.regdst = 2'd1; d.m2r = 2'd2; d.wr = 1'b1; d.jrx = 1'b1; end
                6'h18, 6'h19, 6'h1a, 6'h1b: begin d.alu_op = 3'b010; d.md = 1'b1; end
                default: d.legal = 1'b0;
            endcase
            6'h09: begin d.alu_src = 1'b1; d.wr = 1'b1; end
            6'h0c: begin d.alu_op = 3'b011; d.alu_src = 1'b1; d.zext = 1'b1; d.wr = 1'b1; end
            6'h0d: begin d.alu_op = 3'b100; d.alu_src = 1'b1; d.zext = 1'b1; d.wr = 1'b1; end
            6'h0e: begin d.alu_op = 3'b101; d.alu_src = 1'b1; d.zext = 1'b1; d.wr = 1'b1; end
            6'h0a: begin d.alu_op = 3'b110; d.alu_src = 1'b1; d.wr = 1'b1; end
            6'h0b: begin d.alu_op = 3'b111; d.alu_src = 1'b1; d.wr = 1'b1; end
            6'h0f: begin d.m2r = 2'd3; d.wr = 1'b1; end
            6'h23: begin d.alu_src = 1'b1; d.m2r = 2'd1; d.wr = 1'b1; d.lw = 1'b1; end
            6'h2b: begin d.alu_src = 1'b1; d.sw = 1'b1; end
            6'h04: begin d.alu_op = 3'b001; d.br = 1'b1; end
            6'h05: begin d.alu_op = 3'b001; d.bne = 1'b1; end
            6'h02: d.jump = 1'b1;
            6'h03: begin d.jump = 1'b1; d.regdst = 2'd2; d.m2r = 2'd2; d.wr = 1'b1; end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

    // Expected output vector; fld selects whether decode fields are visible
    function automatic logic [21:0] eo(input info_t d, input bit fld, input bit act, input bit flt,
                                       input bit mr, input bit mw, input bit rw, input bit iw,
                                       input bit pa, input bit pw, input bit ms);
        logic [12:0] f;
        f = fld ? {d.alu_op, d.alu_src, d.zext, d.jump, d.jreg, d.br, d.bne, d.regdst, d.m2r} : 13'b0;
        return {act, flt, f, mr, mw, rw, iw, pa, pw, ms};
    endfunction

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    task automatic push(input bit wr, input bit busy, input logic [2:0] st, input logic [21:0] o);
        cyc_t c;
        c.wr = wr; c.busy = busy; c.st = st; c.out = o;
        tr.push_back(c);
    endtask

    task automatic build(input info_t d, input bit jz, input int fs, input int x1,
                         input int mb, input int x2);
        for (int i = 0; i < fs; i++) push(1'b1, 1'b0, 3'd1, eo(d, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0));
        push(1'b0, 1'b0, 3'd1, eo(d, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0));
        push(rb(), rb(), 3'd2, eo(d, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        if (!d.legal) begin
            for (int i = 0; i < 3; i++) push(rb(), rb(), 3'd7, eo(d, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
            return;
        end
        if (d.lw) begin
            for (int i = 0; i < x1; i++) push(1'b1, 1'b0, 3'd3, eo(d, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0));
            push(1'b0, 1'b0, 3'd3, eo(d, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        end else if (d.md) begin
            push(rb(), 1'b0, 3'd3, eo(d, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
            for (int i = 0; i < mb; i++) push(rb(), 1'b1, 3'd5, eo(d, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
            push(rb(), 1'b0, 3'd5, eo(d, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        end else begin
            push(rb(), rb(), 3'd3, eo(d, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        for (int i = 0; i < x2; i++) push(1'b1, 1'b0, 3'd4, eo(d, 1, 1, 0, 0, d.sw, 0, 0, 0, 0, 0));
        push(1'b0, 1'b0, 3'd4, eo(d, 1, 1, 0, 0, d.sw, d.wr, 0, 0, 1, 0));
        if (d.jrx && jz)
            for (int i = 0; i < 3; i++) push(rb(), rb(), 3'd6, eo(d, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic play(input string tag);
        cyc_t c;
        while (tr.size() > 0) begin
            c = tr.pop_front();
            waitrequest = c.wr;
            alu_busy    = c.busy;
            @(negedge clk);
            check_eq({tag, ".state"}, 32'(state), 32'(c.st));
            check_eq({tag, ".outs"}, 32'(obs), 32'(c.out));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        waitrequest = 1'b1;
        reset = 1'b1;
        #1;
        check_eq("reset.state", 32'(state), 32'd0);
        check_eq("reset.outs", 32'(obs), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn, input bit jz,
                       input int fs, input int x1, input int mb, input int x2);
        info_t d;
        d = decode_ref(op, fn);
        opcode = op;
        funct = fn;
        jr_target_zero = jz;
        build(d, jz, fs, x1, mb, x2);
        play(tag);
        if (!d.legal || (d.jrx && jz)) do_reset();
    endtask

    initial begin
        info_t d;
        logic [5:0] op, fn;
        logic [5:0] ops[13];
        logic [5:0] rfn[24];
        ops = '{6'h09, 6'h0c, 6'h0d, 6'h0e, 6'h0a, 6'h0b, 6'h0f, 6'h23, 6'h2b,
                6'h04, 6'h05, 6'h02, 6'h03};
        rfn = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12, 6'h20, 6'h21,
                6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b, 6'h08, 6'h09,
                6'h18, 6'h19, 6'h1a, 6'h1b};
        reset = 1'b0; waitrequest = 1'b0; alu_busy = 1'b0; jr_target_zero = 1'b0;
        opcode = 6'h09; funct = 6'h00;
        #2;
        do_reset();

        // Reset asserted while FETCH is stalled
        d = decode_ref(6'h09, 6'h00);
        for (int i = 0; i < 2; i++) push(1'b1, 1'b0, 3'd1, eo(d, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0));
        play("fetch_stall");
        do_reset();

        run("addiu",   6'h09, 6'h00, 1'b0, 0, 0, 0, 0);
        run("lw",      6'h23, 6'h00, 1'b0, 0, 3, 0, 0);
        run("sw",      6'h2b, 6'h00, 1'b0, 0, 0, 0, 2);
        run("mult",    6'h00, 6'h18, 1'b0, 0, 0, 5, 0);
        run("jr_halt", 6'h00, 6'h08, 1'b1, 0, 0, 0, 0);
        run("jalr",    6'h00, 6'h09, 1'b0, 1, 0, 0, 1);
        run("jalr_h",  6'h00, 6'h09, 1'b1, 2, 0, 0, 0);
        run("illegal", 6'h3f, 6'h00, 1'b0, 0, 0, 0, 0);
        run("bad_fn",  6'h00, 6'h3f, 1'b0, 1, 0, 0, 0);

        // Stuck waitrequest in FETCH: 4 stalled requests, one silent cycle, then FAULT
        d = decode_ref(6'h09, 6'h00);
        for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 3'd1, eo(d, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0));
        push(1'b1, 1'b0, 3'd1, eo(d, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) push(rb(), rb(), 3'd7, eo(d, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        play("timeout");
        do_reset();

        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 7))
                0: begin op = 6'($urandom_range(0, 63)); fn = 6'($urandom_range(0, 63)); end
                1, 2, 3: begin op = 6'h00; fn = rfn[$urandom_range(0, 23)]; end
                default: begin op = ops[$urandom_range(0, 12)]; fn = 6'($urandom_range(0, 63)); end
            endcase
            run("rand", op, fn, rb(), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 6), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
